// File: rtl/acc_read_ctr_if.sv
// ----------------------------------------------------------------------------
// acc_read_ctr_if : command / read-port / valid-path bundle for acc_read_ctr
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface acc_read_ctr_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  out_valid;
  logic                  out_last;
  logic                  done;

  modport master (
    output start, base_addr, length,
    input  busy, rd_en, rd_addr, out_valid, out_last, done
  );

  modport slave (
    input  start, base_addr, length,
    output busy, rd_en, rd_addr, out_valid, out_last, done
  );
endinterface

`default_nettype wire

// File: rtl/acc_read_ctr.sv
// ----------------------------------------------------------------------------
// acc_read_ctr : accumulator read address sequencer with latency-tracked valid
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module acc_read_ctr #(
  parameter int ADDR_WIDTH   = 9,
  parameter int LEN_WIDTH    = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  acc_read_ctr_if.slave bus
);

  localparam int C_CNT_WIDTH = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [C_CNT_WIDTH-1:0] C_DRAIN_LAST = C_CNT_WIDTH'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                   r_state;
  logic [LEN_WIDTH-1:0]     r_remaining;
  logic [C_CNT_WIDTH-1:0]   r_drain_cnt;
  logic [READ_LATENCY-1:0]  r_valid_pipe;
  logic [READ_LATENCY-1:0]  r_last_pipe;
  logic                     w_final_read;

  // r_remaining counts the read currently on the port, so 1 means final read
  assign w_final_read = bus.rd_en && (r_remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_remaining  <= '0;
      r_drain_cnt  <= '0;
      r_valid_pipe <= '0;
      r_last_pipe  <= '0;
      bus.busy     <= 1'b0;
      bus.rd_en    <= 1'b0;
      bus.rd_addr  <= '0;
      bus.done     <= 1'b0;
    end else if (enable) begin
      r_valid_pipe[0] <= bus.rd_en;
      r_last_pipe[0]  <= w_final_read;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_valid_pipe[i] <= r_valid_pipe[i-1];
        r_last_pipe[i]  <= r_last_pipe[i-1];
      end

      bus.done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            if (bus.length != '0) begin
              r_state     <= RUN;
              r_remaining <= bus.length;
              bus.busy    <= 1'b1;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= bus.base_addr;
            end else begin
              bus.done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (w_final_read) begin
            r_state     <= DRAIN;
            r_drain_cnt <= C_DRAIN_LAST;
            bus.rd_en   <= 1'b0;
          end else begin
            bus.rd_addr <= bus.rd_addr + ADDR_WIDTH'(1);
            r_remaining <= r_remaining - LEN_WIDTH'(1);
          end
        end

        DRAIN: begin
          // done lands one cycle after the last row leaves the delay line
          if (r_drain_cnt == '0) begin
            r_state  <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - C_CNT_WIDTH'(1);
          end
        end

        default: begin
          r_state  <= IDLE;
          bus.busy <= 1'b0;
          bus.rd_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_valid = r_valid_pipe[READ_LATENCY-1];
  assign bus.out_last  = r_last_pipe[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_acc_read_ctr.sv
// ----------------------------------------------------------------------------
// tb_acc_read_ctr : directed bench with burst-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_acc_read_ctr;
  localparam int AW = 9;
  localparam int LW = 16;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;

  acc_read_ctr_if #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  acc_read_ctr #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .READ_LATENCY(RL)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Burst model: k = enabled cycles since the accepted start (cycle 1 = first read)
  bit m_live = 1'b0;
  bit m_active = 1'b0;
  bit m_idle;
  int m_k = 0;
  int m_len = 0;
  int m_base = 0;
  int m_hold = 0;

  function automatic int end_k();
    return (m_len == 0) ? 1 : m_len + RL + 1;
  endfunction

  always @(posedge clk) begin
    m_live = 1'b1;
    if (rst) begin
      m_active = 1'b0;
      m_k = 0;
      m_hold = 0;
    end else if (enable) begin
      m_idle = !m_active || (m_k >= end_k());
      if (m_idle && bus.start) begin
        m_active = 1'b1;
        m_k = 1;
        m_len = int'(bus.length);
        m_base = int'(bus.base_addr);
      end else if (m_active) begin
        m_k++;
      end
      if (m_active && m_len > 0)
        m_hold = (m_base + ((m_k < m_len) ? m_k : m_len) - 1) % (1 << AW);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("rd_en", 32'(bus.rd_en), 32'(m_active && m_len > 0 && m_k <= m_len));
      check("rd_addr", 32'(bus.rd_addr), 32'(m_hold));
      check("busy", 32'(bus.busy), 32'(m_active && m_len > 0 && m_k <= m_len + RL));
      check("out_valid", 32'(bus.out_valid),
            32'(m_active && m_len > 0 && m_k > RL && m_k <= m_len + RL));
      check("out_last", 32'(bus.out_last), 32'(m_active && m_len > 0 && m_k == m_len + RL));
      check("done", 32'(bus.done), 32'(m_active && m_k == end_k()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start during cycle 0 and returns one step into cycle 1
  task automatic issue(input int base, input int len);
    bus.start = 1'b1;
    bus.base_addr = AW'(base);
    bus.length = LW'(len);
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.length = '0;
    rst = 1'b1;
    enable = 1'b1;
    cyc(2);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rd_en", 32'(bus.rd_en), 0);
    check("rst_done", 32'(bus.done), 0);
    rst = 1'b0;
    cyc(1);

    // basic burst base=5 L=4
    issue(5, 4);
    check("t1_addr_c1", 32'(bus.rd_addr), 5);
    cyc(3);
    check("t1_addr_c4", 32'(bus.rd_addr), 8);
    cyc(2);
    check("t1_last_c6", 32'(bus.out_last), 1);
    cyc(1);
    check("t1_done_c7", 32'(bus.done), 1);
    check("t1_busy_c7", 32'(bus.busy), 0);
    cyc(2);

    // address wrap
    issue(510, 4);
    cyc(2);
    check("wrap_addr_c3", 32'(bus.rd_addr), 0);
    cyc(3);
    check("wrap_last_c6", 32'(bus.out_last), 1);
    cyc(3);

    // enable low for 3 cycles mid-run
    issue(0, 5);
    cyc(1);
    check("frz_addr_c2", 32'(bus.rd_addr), 1);
    enable = 1'b0;
    cyc(3);
    check("frz_addr_held", 32'(bus.rd_addr), 1);
    check("frz_rd_en_held", 32'(bus.rd_en), 1);
    enable = 1'b1;
    cyc(6);
    check("frz_done_c11", 32'(bus.done), 1);
    cyc(2);

    // start while busy is ignored, then zero-length start
    issue(100, 2);
    bus.start = 1'b1;
    bus.base_addr = AW'(300);
    bus.length = LW'(7);
    cyc(1);
    bus.start = 1'b0;
    check("busy_addr_c2", 32'(bus.rd_addr), 101);
    cyc(3);
    check("busy_done_c5", 32'(bus.done), 1);
    cyc(1);
    issue(0, 0);
    check("zero_done", 32'(bus.done), 1);
    check("zero_busy", 32'(bus.busy), 0);
    check("zero_rd_en", 32'(bus.rd_en), 0);
    cyc(1);
    check("zero_done_gone", 32'(bus.done), 0);
    cyc(2);

    // back-to-back: second start during done cycle
    issue(0, 3);
    cyc(5);
    check("b2b_done_c6", 32'(bus.done), 1);
    issue(50, 2);
    check("b2b_addr_c7", 32'(bus.rd_addr), 50);
    cyc(1);
    check("b2b_addr_c8", 32'(bus.rd_addr), 51);
    cyc(2);
    check("b2b_last_c10", 32'(bus.out_last), 1);
    cyc(1);
    check("b2b_done_c11", 32'(bus.done), 1);
    cyc(2);

    // reset mid-burst
    issue(20, 6);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("abort_rd_en", 32'(bus.rd_en), 0);
    check("abort_addr", 32'(bus.rd_addr), 0);
    check("abort_valid", 32'(bus.out_valid), 0);
    check("abort_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    cyc(12);
    issue(7, 1);
    check("post_addr", 32'(bus.rd_addr), 7);
    cyc(3);
    check("post_done_c4", 32'(bus.done), 1);
    cyc(2);

    // start while enable is low is ignored
    enable = 1'b0;
    bus.start = 1'b1;
    bus.length = LW'(3);
    cyc(2);
    bus.start = 1'b0;
    enable = 1'b1;
    cyc(3);
    check("dis_start_busy", 32'(bus.busy), 0);

    // maximum length burst
    issue(0, 65535);
    n = 1;
    while (!bus.done && n < 70000) begin
      cyc(1);
      n++;
    end
    check("max_done_cycle", 32'(n), 65538);
    check("max_last_addr", 32'(bus.rd_addr), 510);
    cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
